// File: rtl/uart_rx_frame_controller.sv
// uart_rx_frame_controller
// Receives bytes from a UART receiver over a 4-phase RxReady/RxAck handshake.
// Parses frames of the form A5, LEN, LEN payload bytes, CHK.
// A frame that checks out is buffered and then drained to a consumer over a
// valid/ready stream.
//
// Handshake semantics:
//   Receiver side : a byte is accepted in any cycle with RxReady=1 and RxAck=0
//                   (never in DRAIN). RxAck rises on the next edge and stays
//                   high until the first cycle RxReady=0 is seen.
//   Consumer side : a payload byte transfers in every cycle with
//                   FrameValid=1 and FrameReady=1. FrameData/FrameLast are
//                   stable while FrameValid=1 and FrameReady=0.
// State is exported on the State port (IDLE=0, LEN=1, PAYLOAD=2, CHECK=3,
// DRAIN=4) so that checkers can observe the FSM directly.
module uart_rx_frame_controller #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] RxData,
  input  logic       RxReady,
  output logic       RxAck,
  output logic       RxSoftReset,
  output logic [7:0] FrameData,
  output logic       FrameValid,
  input  logic       FrameReady,
  output logic       FrameLast,
  output logic       FrameDone,
  output logic       FrameError,
  output logic [1:0] ErrCode,
  output logic       Busy,
  output logic [2:0] State
);

  // A one-byte buffer still needs a 1-bit pointer.
  localparam int PTR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CHKSUM  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               ack_q, ack_d;
  logic               soft_q, soft_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         chk_q, chk_d;
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_q, rd_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               mem_we;
  logic [7:0]         frame_mem [MAX_LEN];

  logic accept;
  logic in_timed;
  logic tmo_hit;
  logic wr_last;
  logic rd_last;
  logic xfer;

  // Handshake qualifiers and pointer/timeout conditions used by the FSM.
  always_comb begin
    accept   = RxReady && !ack_q && (state_q != S_DRAIN);
    in_timed = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // An accepted byte in the same cycle wins over the timeout.
    tmo_hit  = in_timed && (tmo_q == TMO_LIMIT) && !accept;
    wr_last  = (8'(wr_q) == (len_q - 8'd1));
    rd_last  = (8'(rd_q) == (len_q - 8'd1));
    xfer     = (state_q == S_DRAIN) && FrameReady;
  end

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    soft_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    len_d   = len_q;
    chk_d   = chk_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_we  = 1'b0;

    // RxAck rises on accept, falls once the receiver drops RxReady.
    ack_d = ack_q;
    if (accept) begin
      ack_d = 1'b1;
    end else if (ack_q && !RxReady) begin
      ack_d = 1'b0;
    end

    // The idle-gap counter restarts on every byte and only runs mid-frame.
    if (accept || !in_timed) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    if (tmo_hit) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      soft_d  = 1'b1;
      tmo_d   = '0;
      wr_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && (RxData == SYNC_BYTE)) begin
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          if (accept) begin
            if ((RxData == 8'd0) || (RxData > MAX_LEN_B)) begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_LEN;
            end else begin
              state_d = S_PAYLOAD;
              len_d   = RxData;
              chk_d   = RxData;
              wr_d    = '0;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            mem_we = 1'b1;
            chk_d  = chk_q + RxData;
            wr_d   = wr_q + PTR_W'(1);
            if (wr_last) begin
              state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (RxData == chk_q) begin
              state_d = S_DRAIN;
              rd_d    = '0;
            end else begin
              state_d = S_IDLE;
              err_d   = 1'b1;
              code_d  = ERR_CHKSUM;
              wr_d    = '0;
            end
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            if (rd_last) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
              rd_d    = '0;
              wr_d    = '0;
            end else begin
              rd_d = rd_q + PTR_W'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and control registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      soft_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
      len_q   <= 8'd0;
      chk_q   <= 8'd0;
      wr_q    <= '0;
      rd_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      soft_q  <= soft_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
    end
  end

  // Payload buffer; contents are not reset since a frame is only ever read
  // after it has been fully written and checked.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      frame_mem[wr_q] <= RxData;
    end
  end

  // Output decode; FrameData is forced to 0 outside DRAIN so reset zeroes it.
  always_comb begin
    RxAck       = ack_q;
    RxSoftReset = soft_q;
    FrameDone   = done_q;
    FrameError  = err_q;
    ErrCode     = code_q;
    FrameValid  = (state_q == S_DRAIN);
    FrameData   = FrameValid ? frame_mem[rd_q] : 8'h00;
    FrameLast   = FrameValid && rd_last;
    Busy        = (state_q != S_IDLE);
    State       = state_q;
  end

endmodule

// File: tb/tb_uart_rx_frame_controller.sv
// Directed bench for uart_rx_frame_controller.
module tb_uart_rx_frame_controller;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 40;

  logic       Clk;
  logic       Reset;
  logic [7:0] RxData;
  logic       RxReady;
  logic       RxAck;
  logic       RxSoftReset;
  logic [7:0] FrameData;
  logic       FrameValid;
  logic       FrameReady;
  logic       FrameLast;
  logic       FrameDone;
  logic       FrameError;
  logic [1:0] ErrCode;
  logic       Busy;
  logic [2:0] State;

  uart_rx_frame_controller #(.MAX_LEN(MAX_LEN), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset(Reset), .RxData(RxData), .RxReady(RxReady), .RxAck(RxAck),
    .RxSoftReset(RxSoftReset), .FrameData(FrameData), .FrameValid(FrameValid),
    .FrameReady(FrameReady), .FrameLast(FrameLast), .FrameDone(FrameDone),
    .FrameError(FrameError), .ErrCode(ErrCode), .Busy(Busy), .State(State)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks  = 0;
  int n_errors  = 0;
  int err_cnt   = 0;
  int done_cnt  = 0;
  int soft_cnt  = 0;
  int valid_cnt = 0;

  // Scoreboard: expected {FrameLast, FrameData} per consumer transfer.
  logic [8:0] exp_q[$];
  logic [7:0] seq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: counts pulses and scores every consumer transfer.
  always @(negedge Clk) begin
    if (Reset) begin
      if (FrameError)  err_cnt++;
      if (FrameDone)   done_cnt++;
      if (RxSoftReset) soft_cnt++;
      if (FrameValid)  valid_cnt++;
      if (FrameValid && FrameReady) begin
        if (exp_q.size() == 0) begin
          check("extra_xfer", 32'(FrameValid), 32'd0);
        end else begin
          check("xfer", 32'({FrameLast, FrameData}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // Driver: one 4-phase handshake per byte, bounded waits.
  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1;
    RxData  = b;
    RxReady = 1'b1;
    for (int i = 0; i < 20 && !RxAck; i++) begin
      @(posedge Clk); #1;
    end
    check("ack_rise", 32'(RxAck), 32'd1);
    RxReady = 1'b0;
    for (int i = 0; i < 20 && RxAck; i++) begin
      @(posedge Clk); #1;
    end
    check("ack_fall", 32'(RxAck), 32'd0);
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(RxAck),       32'd0);
    check({tag, "_soft"},  32'(RxSoftReset), 32'd0);
    check({tag, "_data"},  32'(FrameData),   32'd0);
    check({tag, "_valid"}, 32'(FrameValid),  32'd0);
    check({tag, "_last"},  32'(FrameLast),   32'd0);
    check({tag, "_done"},  32'(FrameDone),   32'd0);
    check({tag, "_err"},   32'(FrameError),  32'd0);
    check({tag, "_code"},  32'(ErrCode),     32'd0);
    check({tag, "_busy"},  32'(Busy),        32'd0);
    check({tag, "_state"}, 32'(State),       32'd0);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, d0, s0, v0;
    Reset = 1'b0; RxData = 8'h00; RxReady = 1'b0; FrameReady = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge Clk); Reset = 1'b1;
    wait_cycles(2);

    // Good frame, consumer always ready.
    FrameReady = 1'b1;
    e0 = err_cnt; d0 = done_cnt;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_bytes(seq);
    wait_cycles(8);
    check("good_left", 32'(exp_q.size()), 32'd0);
    check("good_done", 32'(done_cnt - d0), 32'd1);
    check("good_err",  32'(err_cnt - e0),  32'd0);
    check("good_busy", 32'(Busy), 32'd0);

    // Bad checksum.
    e0 = err_cnt; v0 = valid_cnt;
    seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    send_bytes(seq);
    wait_cycles(4);
    check("chk_err",   32'(err_cnt - e0),   32'd1);
    check("chk_code",  32'(ErrCode),        32'd3);
    check("chk_valid", 32'(valid_cnt - v0), 32'd0);
    check("chk_busy",  32'(Busy),           32'd0);

    // Zero length.
    e0 = err_cnt;
    seq = '{8'hA5, 8'h00};
    send_bytes(seq);
    wait_cycles(3);
    check("len0_err",  32'(err_cnt - e0), 32'd1);
    check("len0_code", 32'(ErrCode),      32'd1);

    // Length one above MAX_LEN.
    e0 = err_cnt;
    seq = '{8'hA5, 8'h11};
    send_bytes(seq);
    wait_cycles(3);
    check("len17_err",   32'(err_cnt - e0), 32'd1);
    check("len17_code",  32'(ErrCode),      32'd1);
    check("len17_state", 32'(State),        32'd0);

    // Timeout after A5 02.
    e0 = err_cnt; s0 = soft_cnt;
    seq = '{8'hA5, 8'h02};
    send_bytes(seq);
    check("tmo_busy_pre", 32'(Busy), 32'd1);
    wait_cycles(TMO + 10);
    check("tmo_err",   32'(err_cnt - e0),  32'd1);
    check("tmo_code",  32'(ErrCode),       32'd2);
    check("tmo_soft",  32'(soft_cnt - s0), 32'd1);
    check("tmo_state", 32'(State),         32'd0);

    // Gaps shorter than the timeout keep the frame alive.
    e0 = err_cnt; d0 = done_cnt;
    exp_q.push_back({1'b1, 8'h5A});
    seq = '{8'hA5, 8'h01};
    send_bytes(seq);
    wait_cycles(TMO - 10);
    send_byte(8'h5A);
    wait_cycles(TMO - 10);
    send_byte(8'h5B);
    wait_cycles(4);
    check("gap_err",  32'(err_cnt - e0),  32'd0);
    check("gap_done", 32'(done_cnt - d0), 32'd1);
    check("gap_left", 32'(exp_q.size()),  32'd0);

    // Junk before sync, consumer stalled, then one accept.
    FrameReady = 1'b0;
    d0 = done_cnt;
    exp_q.push_back({1'b1, 8'h7E});
    seq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    send_bytes(seq);
    @(negedge Clk);
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", 32'(FrameValid), 32'd1);
      check("hold_data",  32'(FrameData),  32'h7E);
      check("hold_last",  32'(FrameLast),  32'd1);
      @(negedge Clk);
    end
    @(posedge Clk); #1; FrameReady = 1'b1;
    @(posedge Clk); #1; FrameReady = 1'b0;
    wait_cycles(3);
    check("stall_done", 32'(done_cnt - d0), 32'd1);
    check("stall_left", 32'(exp_q.size()),  32'd0);
    check("stall_busy", 32'(Busy),          32'd0);

    // Asynchronous reset mid-frame while RxAck is high.
    FrameReady = 1'b1;
    seq = '{8'hA5, 8'h04};
    send_bytes(seq);
    @(posedge Clk); #1;
    RxData = 8'hAA; RxReady = 1'b1;
    for (int i = 0; i < 20 && !RxAck; i++) begin
      @(posedge Clk); #1;
    end
    check("rst_ack_pre",  32'(RxAck), 32'd1);
    check("rst_busy_pre", 32'(Busy),  32'd1);
    #2 Reset = 1'b0;
    #1 check_all_zero("midrst");
    RxReady = 1'b0;
    @(negedge Clk); Reset = 1'b1;
    wait_cycles(2);

    // Clean frame after reset.
    d0 = done_cnt; e0 = err_cnt;
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b1, 8'h20});
    seq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    send_bytes(seq);
    wait_cycles(6);
    check("post_done", 32'(done_cnt - d0), 32'd1);
    check("post_err",  32'(err_cnt - e0),  32'd0);
    check("post_left", 32'(exp_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
